stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control FSM that sequences the seconds/minutes counter datapath and seven-segment display.
- Debounces three raw push-buttons: start/stop, lap, clear.
- Generates the 1 Hz count-enable tick from the system clock, a display-freeze (lap) level, and a clear pulse.
- Detects the elapsed-time limit and parks in DONE; the datapath counts only on the tick from this block.

Parameters:
- TICK_DIV, 12000000: system-clock cycles per count tick (1 s).
- DEBOUNCE_CYC, 240000: cycles a key level must stay stable before it is accepted (20 ms).
- LIMIT_SEC, 480: elapsed seconds at which the run ends.
- SEC_W, 9: width of the elapsed-seconds input.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- key_start  in  1  raw start/stop button, active-low, asynchronous.
- key_lap  in  1  raw lap button, active-low, asynchronous.
- key_clr  in  1  raw clear button, active-low, asynchronous.
- elapsed  in  SEC_W  total elapsed seconds reported by the counter datapath.
- tick  out  1  one-cycle count-enable pulse to the datapath.
- clr  out  1  one-cycle synchronous clear to the datapath.
- freeze  out  1  level: display holds its latched value (lap view).
- done  out  1  level: limit reached.
- state  out  3  current FSM state, for LEDs/debug.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; tick=0, clr=0, freeze=0, done=0; prescaler=0; debouncers hold the released level with no press pending.
- Key path, per key:
  - 2-FF synchronizer, then stability counter.
  - The new level is accepted after DEBOUNCE_CYC consecutive equal samples.
  - Accepted 1->0 transition produces press=1 for exactly one cycle; release produces no pulse.
  - Latency from stable raw edge to press is DEBOUNCE_CYC+2 cycles.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and LAP; held in PAUSE; zero in IDLE and DONE.
  - tick is registered: tick=1 in the cycle after the prescaler reaches TICK_DIV-1 while counting.
  - Counting resumes from the held value after PAUSE, so no partial second is lost.
- States, encoded in the package: IDLE=0, RUN=1, LAP=2, PAUSE=3, DONE=4.
- Event priority within one cycle: clr press > limit > start press > lap press. Lower-priority presses arriving in the same cycle are dropped.
- Limit condition: elapsed >= LIMIT_SEC, evaluated in RUN and LAP.
- Transitions:
  - IDLE: start -> RUN with prescaler 0, so the first tick comes TICK_DIV cycles later. lap is ignored; clr re-pulses clr.
  - RUN: clr -> IDLE; limit -> DONE; start -> PAUSE; lap -> LAP.
  - LAP: clr -> IDLE; limit -> DONE; start -> PAUSE; lap -> RUN.
  - PAUSE: clr -> IDLE; start -> RUN; lap ignored.
  - DONE: clr -> IDLE; start and lap ignored.
- clr output: 1 for exactly one cycle, in the cycle after any accepted clr press (any state).
- freeze=1 only in LAP. It drops in the same cycle the FSM leaves LAP.
- done=1 only in DONE.
- Simultaneous events:
  - Prescaler wrap in the same cycle as a start press in RUN: the tick is still issued, then PAUSE.
  - Wrap in the same cycle as a clr press: the tick is suppressed.
- The limit is hit while in LAP: go to DONE with freeze=0, so the display shows the final value.
- No ticks are issued in DONE, even if elapsed later drops below the limit; only clr leaves DONE.
- Reset mid-operation: all outputs and state return to reset values immediately; a key held across reset release produces no press until released and re-pressed.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding constants (width 3);
  - default TICK_DIV, DEBOUNCE_CYC, LIMIT_SEC;
  - the function computing the prescaler and debounce counter widths (ceil log2).
- One sub-module, key_debounce (synchronizer + stability counter + press pulse), instantiated three times.
- FSM, prescaler and output logic stay in stopwatch_ctrl.

Test Plan:
(Bench parameters: TICK_DIV=10, DEBOUNCE_CYC=4, LIMIT_SEC=3; the bench model increments elapsed on each tick.)
- Reset, then hold key_start low 10 cycles -> one press; state IDLE->RUN; first tick exactly 10 cycles after entry; ticks every 10 cycles; tick never 2 cycles wide.
- Bounce key_start (toggle every 2 cycles for 12 cycles) then release -> zero press pulses; state stays IDLE.
- In RUN, press start at prescaler=6 -> PAUSE, tick stops; press start again -> next tick after 3 more cycles (resumed, not restarted).
- In RUN, press lap -> freeze=1, ticks continue; press lap -> freeze=0, state RUN.
- Run until elapsed=3 -> state DONE, done=1, no further ticks; start and lap ignored; press clr -> clr pulse of 1 cycle, state IDLE, done=0.
- clr and start pressed the same cycle in RUN -> IDLE, clr pulse, no PAUSE. Assert rst mid-RUN with key_lap held -> all outputs 0 immediately, no lap press after release of rst.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : stopwatch_pkg
//  Purpose : Shared definitions for the stopwatch control block. Holds the
//            FSM state encoding, the default timing constants and the helper
//            that sizes the prescaler and debounce counters.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

  // FSM state encoding, also visible on the state output for LEDs/debug.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_LAP   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Default timing for a 12 MHz system clock.
  localparam int unsigned DEF_TICK_DIV     = 12000000; // cycles per 1 s tick
  localparam int unsigned DEF_DEBOUNCE_CYC = 240000;   // 20 ms stable window
  localparam int unsigned DEF_LIMIT_SEC    = 480;      // run ends at 8 minutes

  // Positions of the three keys inside the press vector.
  localparam int unsigned KEY_START = 0;
  localparam int unsigned KEY_LAP   = 1;
  localparam int unsigned KEY_CLR   = 2;

  // Number of bits needed to count 0..n-1 (ceil log2, never less than 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/stopwatch_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module  : key_debounce
//  Purpose : Conditions one raw active-low push-button. A 2-FF synchronizer
//            feeds a stability counter; a new level is accepted once it has
//            been sampled DEBOUNCE_CYC times in a row. An accepted press
//            (1->0) yields a single-cycle press pulse, a release yields none.
//  Ports   : clk      in  system clock
//            rst      in  asynchronous reset, active-low
//            key_raw  in  raw button level, active-low, asynchronous
//            press    out one-cycle pulse on an accepted press
//  Rev     : 1.0  initial release
// ============================================================================
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          level;   // accepted (debounced) key level, 1 = released
  logic          armed;   // a genuine released level has been seen since reset
  logic [1:0]    warm;    // synchronizer fill count after reset
  logic [CW-1:0] cnt;     // consecutive samples differing from level

  // The synchronizer stages reset to the released level, so for the first
  // two cycles after reset sync2 does not yet reflect the pin. Pulses are
  // only allowed once a real released sample has been observed, which keeps
  // a key held across reset from producing a press until it is re-pressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      armed <= 1'b0;
      warm  <= 2'd0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      press <= 1'b0;

      if (warm != 2'd2) begin
        warm <= warm + 2'd1;
      end

      if (warm == 2'd2 && level && sync2) begin
        armed <= 1'b1;
      end

      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= armed & ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule : key_debounce
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : stopwatch_ctrl
//  Purpose : Control FSM for a seconds/minutes stopwatch. Debounces the
//            start/stop, lap and clear buttons, divides the system clock into
//            a 1 Hz count-enable tick, drives the lap freeze level and the
//            datapath clear pulse, and parks in DONE at the elapsed limit.
//  Ports   : clk        in  system clock
//            rst        in  asynchronous reset, active-low
//            key_start  in  raw start/stop button, active-low
//            key_lap    in  raw lap button, active-low
//            key_clr    in  raw clear button, active-low
//            elapsed    in  total elapsed seconds from the datapath
//            tick       out one-cycle count enable to the datapath
//            clr        out one-cycle synchronous clear to the datapath
//            freeze     out display hold (lap view) level
//            done       out limit reached level
//            state      out current FSM state
//  Rev     : 1.0  initial release
// ============================================================================
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned LIMIT_SEC    = DEF_LIMIT_SEC,
  parameter int unsigned SEC_W        = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_lap,
  input  logic             key_clr,
  input  logic [SEC_W-1:0] elapsed,
  output logic             tick,
  output logic             clr,
  output logic             freeze,
  output logic             done,
  output logic [2:0]       state
);

  localparam int unsigned      PW         = cnt_width(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0] LIMIT_VAL  = SEC_W'(LIMIT_SEC);

  // --------------------------------------------------------------------------
  // Key conditioning
  // --------------------------------------------------------------------------
  logic [2:0] keys_raw;
  logic [2:0] press;

  assign keys_raw = {key_clr, key_lap, key_start};

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .key_raw (keys_raw[i]),
      .press   (press[i])
    );
  end

  logic press_start;
  logic press_lap;
  logic press_clr;

  assign press_start = press[KEY_START];
  assign press_lap   = press[KEY_LAP];
  assign press_clr   = press[KEY_CLR];

  // --------------------------------------------------------------------------
  // FSM and prescaler
  // --------------------------------------------------------------------------
  state_t        state_q;
  state_t        state_nx;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_nx;
  logic          counting;
  logic          wrap;
  logic          limit_hit;
  logic          tick_nx;

  assign counting  = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign wrap      = counting && (presc_q == PRESC_LAST);
  assign limit_hit = (elapsed >= LIMIT_VAL);

  // Priority: clear, then limit, then start/stop, then lap. Anything of lower
  // priority arriving in the same cycle is simply dropped.
  always_comb begin
    state_nx = state_q;
    if (press_clr) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (press_start) state_nx = ST_RUN;
        end
        ST_RUN: begin
          if (limit_hit)        state_nx = ST_DONE;
          else if (press_start) state_nx = ST_PAUSE;
          else if (press_lap)   state_nx = ST_LAP;
        end
        ST_LAP: begin
          if (limit_hit)        state_nx = ST_DONE;
          else if (press_start) state_nx = ST_PAUSE;
          else if (press_lap)   state_nx = ST_RUN;
        end
        ST_PAUSE: begin
          if (press_start) state_nx = ST_RUN;
        end
        ST_DONE: begin
          state_nx = ST_DONE;
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // The prescaler keeps its value through PAUSE so that resuming finishes the
  // partial second; it is zeroed whenever the run stops for good, which also
  // gives a full TICK_DIV period before the first tick after a start.
  always_comb begin
    presc_nx = presc_q;
    if (state_nx == ST_IDLE || state_nx == ST_DONE) begin
      presc_nx = '0;
    end else if (counting) begin
      presc_nx = wrap ? '0 : presc_q + PW'(1);
    end
  end

  // A wrap coinciding with a start/stop press still produces its tick; a
  // coinciding clear suppresses it so the cleared datapath stays at zero.
  assign tick_nx = wrap && !press_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      tick    <= 1'b0;
      clr     <= 1'b0;
    end else begin
      state_q <= state_nx;
      presc_q <= presc_nx;
      tick    <= tick_nx;
      clr     <= press_clr;
    end
  end

  // --------------------------------------------------------------------------
  // Level outputs straight from the state register
  // --------------------------------------------------------------------------
  assign freeze = (state_q == ST_LAP);
  assign done   = (state_q == ST_DONE);
  assign state  = state_q;

endmodule : stopwatch_ctrl
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_stopwatch_ctrl
//  Purpose : Self-checking bench for stopwatch_ctrl with small timing
//            parameters. A behavioural model derived from the key, prescaler
//            and state rules predicts every output each cycle; the bench
//            also acts as the counter datapath, bumping elapsed on each tick.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int TD  = 10;
  localparam int DB  = 4;
  localparam int LIM = 3;

  localparam int K_START = 0;
  localparam int K_LAP   = 1;
  localparam int K_CLR   = 2;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_LAP   = 2;
  localparam int S_PAUSE = 3;
  localparam int S_DONE  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic [8:0] elapsed = '0;
  logic       tick;
  logic       clr;
  logic       freeze;
  logic       done;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .TICK_DIV     (TD),
    .DEBOUNCE_CYC (DB),
    .LIMIT_SEC    (LIM),
    .SEC_W        (9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_start (key_n[K_START]),
    .key_lap   (key_n[K_LAP]),
    .key_clr   (key_n[K_CLR]),
    .elapsed   (elapsed),
    .tick      (tick),
    .clr       (clr),
    .freeze    (freeze),
    .done      (done),
    .state     (state)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int         m_state;
  int         m_presc;   // cycles already counted toward the current second
  bit         m_tick;
  bit         m_clr;
  bit [DB+1:0] m_hist[3]; // raw samples, bit 0 = newest
  bit         m_level[3];
  bit         m_armed[3];
  bit         m_press[3];
  int         m_warm;

  task automatic model_reset();
    m_state = S_IDLE;
    m_presc = 0;
    m_tick  = 0;
    m_clr   = 0;
    m_warm  = 0;
    for (int k = 0; k < 3; k++) begin
      m_hist[k]  = '1;
      m_level[k] = 1;
      m_armed[k] = 0;
      m_press[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit lim;
    bit run;
    bit wrap;
    int ns;
    int np;
    bit new_press[3];
    bit [DB-1:0] win;
    bit arm_nx;
    if (!rst) begin
      model_reset();
      return;
    end
    lim  = (elapsed >= LIM);
    run  = (m_state == S_RUN || m_state == S_LAP);
    wrap = run && (m_presc == TD - 1);
    ns   = m_state;
    if (m_press[K_CLR]) ns = S_IDLE;
    else begin
      case (m_state)
        S_IDLE, S_PAUSE: if (m_press[K_START]) ns = S_RUN;
        S_RUN, S_LAP: begin
          if (lim)                   ns = S_DONE;
          else if (m_press[K_START]) ns = S_PAUSE;
          else if (m_press[K_LAP])   ns = (m_state == S_RUN) ? S_LAP : S_RUN;
        end
        default: ;
      endcase
    end
    if (ns == S_IDLE || ns == S_DONE) np = 0;
    else if (run)                     np = (m_presc + 1) % TD;
    else                              np = m_presc;
    m_tick = wrap && !m_press[K_CLR];
    m_clr  = m_press[K_CLR];

    // A level is accepted when the last DB synchronized samples (which lag
    // the pin by two cycles) all disagree with the accepted level.
    m_warm++;
    for (int k = 0; k < 3; k++) begin
      m_hist[k]    = {m_hist[k][DB:0], key_n[k]};
      win          = m_hist[k][DB+1:2];
      new_press[k] = 0;
      arm_nx       = m_armed[k] || (m_warm >= 3 && m_level[k] && m_hist[k][2]);
      if (m_level[k] && win == '0) begin
        m_level[k]   = 0;
        new_press[k] = m_armed[k];
      end else if (!m_level[k] && win == '1) begin
        m_level[k] = 1;
      end
      m_armed[k] = arm_nx;
    end
    m_state = ns;
    m_presc = np;
    for (int k = 0; k < 3; k++) m_press[k] = new_press[k];
  endtask

  // ---------------------------------------------------------------------------
  // Checking and stepping
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check("tick",   int'(tick),   int'(m_tick));
    check("clr",    int'(clr),    int'(m_clr));
    check("state",  int'(state),  m_state);
    check("freeze", int'(freeze), int'(m_state == S_LAP));
    check("done",   int'(done),   int'(m_state == S_DONE));
    if (!rst || clr) elapsed = '0;
    else if (tick)   elapsed = elapsed + 9'd1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int n;
    n = 0;
    while (int'(state) != s && n < budget) begin
      step();
      n++;
    end
    check(tag, int'(state), s);
  endtask

  task automatic wait_tick(input int budget, input string tag);
    int n;
    n = 0;
    while (tick !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, int'(tick), 1);
  endtask

  task automatic press_key(input int k, input int hold);
    key_n[k] = 1'b0;
    steps(hold);
    key_n[k] = 1'b1;
    steps(DB + 4);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t0;
    int nt;
    int r;
    int k2;
    model_reset();

    // Reset state
    steps(3);
    check("rst_state", int'(state), S_IDLE);
    check("rst_outs",  int'({tick, clr, freeze, done}), 0);
    rst = 1'b1;
    steps(6);

    // Bouncing start key: every level shorter than the window
    for (int i = 0; i < 6; i++) begin
      key_n[K_START] = ~key_n[K_START];
      steps(2);
    end
    key_n[K_START] = 1'b1;
    steps(10);
    check("bounce_idle", int'(state), S_IDLE);

    // Start, first tick latency
    key_n[K_START] = 1'b0;
    wait_state(S_RUN, 20, "run_entry");
    t0 = cyc;
    key_n[K_START] = 1'b1;
    wait_tick(30, "tick1");
    check("tick1_lat", cyc - t0, TD);

    // Pause with the prescaler at 6, resume completes the second
    key_n[K_START] = 1'b0;
    wait_state(S_PAUSE, 20, "pause_entry");
    key_n[K_START] = 1'b1;
    nt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      nt += int'(tick);
    end
    check("pause_no_tick", nt, 0);
    key_n[K_START] = 1'b0;
    wait_state(S_RUN, 20, "resume");
    t0 = cyc;
    key_n[K_START] = 1'b1;
    wait_tick(20, "tick_resume");
    check("resume_lat", cyc - t0, 3);
    t0 = cyc;
    step();
    check("tick_width", int'(tick), 0);
    wait_tick(20, "tick_period");
    check("tick_period_len", cyc - t0, TD);

    // Limit reached from RUN; DONE ignores start/lap and falling elapsed
    wait_state(S_DONE, 5, "done_run");
    check("done_lvl", int'(done), 1);
    press_key(K_START, 8);
    press_key(K_LAP, 8);
    elapsed = '0;
    steps(12);
    check("done_sticky", int'(state), S_DONE);
    key_n[K_CLR] = 1'b0;
    wait_state(S_IDLE, 20, "clr_exit");
    check("clr_pulse", int'(clr), 1);
    key_n[K_CLR] = 1'b1;
    step();
    check("clr_one", int'(clr), 0);
    check("done_clear", int'(done), 0);
    steps(8);

    // Lap toggle while running
    key_n[K_START] = 1'b0;
    wait_state(S_RUN, 20, "run2");
    key_n[K_START] = 1'b1;
    steps(2);
    key_n[K_LAP] = 1'b0;
    wait_state(S_LAP, 20, "lap_entry");
    check("lap_freeze", int'(freeze), 1);
    key_n[K_LAP] = 1'b1;
    wait_tick(20, "lap_tick");
    check("lap_freeze_tick", int'(freeze), 1);
    steps(6);
    key_n[K_LAP] = 1'b0;
    wait_state(S_RUN, 20, "lap_exit");
    check("lap_unfreeze", int'(freeze), 0);
    key_n[K_LAP] = 1'b1;
    wait_state(S_DONE, 40, "done_run2");
    press_key(K_CLR, 8);

    // Limit reached while in LAP
    key_n[K_START] = 1'b0;
    wait_state(S_RUN, 20, "run3");
    key_n[K_START] = 1'b1;
    steps(2);
    key_n[K_LAP] = 1'b0;
    wait_state(S_LAP, 20, "lap3");
    key_n[K_LAP] = 1'b1;
    wait_state(S_DONE, 50, "done_lap");
    check("done_lap_freeze", int'(freeze), 0);
    press_key(K_CLR, 8);

    // Clear and start in the same cycle while running
    key_n[K_START] = 1'b0;
    wait_state(S_RUN, 20, "run4");
    key_n[K_START] = 1'b1;
    steps(8);
    key_n[K_START] = 1'b0;
    key_n[K_CLR]   = 1'b0;
    wait_state(S_IDLE, 20, "clr_start");
    check("clr_start_pulse", int'(clr), 1);
    step();
    check("clr_start_nopause", int'(state), S_IDLE);
    key_n = 3'b111;
    steps(8);

    // Randomized key activity
    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 9);
      k2 = (r < 4) ? K_START : (r < 8) ? K_LAP : K_CLR;
      key_n[k2] = 1'b0;
      if ($urandom_range(0, 5) == 0) key_n[$urandom_range(0, 2)] = 1'b0;
      steps($urandom_range(1, 12));
      key_n = 3'b111;
      steps($urandom_range(0, 10));
    end
    steps(10);

    // Reset mid-RUN with keys held across reset release
    press_key(K_CLR, 8);
    key_n[K_START] = 1'b0;
    wait_state(S_RUN, 20, "run5");
    key_n[K_START] = 1'b1;
    steps(8);
    key_n[K_LAP]   = 1'b0;
    key_n[K_START] = 1'b0;
    steps(2);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_rst_state", int'(state), S_IDLE);
    check("async_rst_outs",  int'({tick, clr, freeze, done}), 0);
    steps(3);
    rst = 1'b1;
    steps(20);
    check("held_no_press", int'(state), S_IDLE);
    key_n = 3'b111;
    steps(8);
    key_n[K_START] = 1'b0;
    wait_state(S_RUN, 20, "run_after_rst");
    key_n[K_START] = 1'b1;
    steps(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc %0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule : tb_stopwatch_ctrl
`default_nettype wire
